// File: rtl/bcd_calc_sequencer_if.sv
// bcd_calc_sequencer_if: keypad key handshake between a key source (master) and the sequencer (slave)
interface bcd_calc_sequencer_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   modport master (output key_valid, key_code, input key_ready);
   modport slave (input key_valid, key_code, output key_ready);
endinterface

// File: rtl/bcd_calc_sequencer.sv
// bcd_calc_sequencer: keypad-driven 2-digit BCD add/subtract sequencer; define BCD_CALC_CHAIN_EN to chain +/- from a result
module bcd_calc_sequencer (
   input  logic                       clk,
   input  logic                       nrst,
   bcd_calc_sequencer_if.slave        key,
   output logic [7:0]                 add_a,
   output logic [7:0]                 add_b,
   output logic                       add_sub,
   input  logic [7:0]                 add_o,
   output logic [7:0]                 result,
   output logic                       result_valid,
   output logic [7:0]                 display
);
   typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, RESULT} state_t;
   state_t state;
   logic acc, is_dig, is_op, is_eq, is_clr;
   assign key.key_ready = state != CALC;
   assign acc = key.key_valid & key.key_ready;
   assign is_dig = key.key_code <= 4'd9;
   assign is_op = key.key_code == 4'hA || key.key_code == 4'hB;
   assign is_eq = key.key_code == 4'hC;
   assign is_clr = key.key_code == 4'hF;
   // Show the operand being entered, B while the adder runs, then the captured result
   always_comb display = state == ENTER_A ? add_a : state == RESULT ? result : add_b;
   // Sequencer: key decode per state; CALC is a single cycle that captures the adder output
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= ENTER_A;
         add_a <= 8'h00;
         add_b <= 8'h00;
         add_sub <= 1'b0;
         result <= 8'h00;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (state == CALC) begin
            result <= add_o;
            result_valid <= 1'b1;
            state <= RESULT;
         end else if (acc) begin
            if (is_clr) begin
               state <= ENTER_A;
               add_a <= 8'h00;
               add_b <= 8'h00;
               add_sub <= 1'b0;
               result <= 8'h00;
            end else case (state)
               ENTER_A:
                  if (is_dig) add_a <= {add_a[3:0], key.key_code};
                  else if (is_op) begin
                     add_sub <= key.key_code[0];
                     add_b <= 8'h00;
                     state <= ENTER_B;
                  end else if (is_eq) begin
                     add_sub <= 1'b0;
                     add_b <= 8'h00;
                     state <= CALC;
                  end
               ENTER_B:
                  if (is_dig) add_b <= {add_b[3:0], key.key_code};
                  else if (is_op) add_sub <= key.key_code[0];
                  else if (is_eq) state <= CALC;
               RESULT:
                  if (is_dig) begin
                     add_a <= {4'h0, key.key_code};
                     add_b <= 8'h00;
                     add_sub <= 1'b0;
                     state <= ENTER_A;
                  end
`ifdef BCD_CALC_CHAIN_EN
                  else if (is_op) begin
                     add_a <= result;
                     add_b <= 8'h00;
                     add_sub <= key.key_code[0];
                     state <= ENTER_B;
                  end
`endif
               default: ;
            endcase
         end
      end
endmodule
